// File: rtl/serdes_pkg.sv
// Shared types and constants for the SERDES word aligner.
// The FSM state encoding, the default training word and the word width live here.
package serdes_pkg;

    localparam int unsigned SERDES_DATA_WIDTH    = 8;
    localparam logic [7:0]  SERDES_TRAIN_PATTERN = 8'hB4;

    typedef enum logic [1:0] {
        ST_SEARCH   = 2'd0,
        ST_SETTLING = 2'd1,
        ST_VERIFY   = 2'd2,
        ST_LOCKED   = 2'd3
    } state_e;

    // Bit offsets form a ring 0..7; stepping past 7 returns to 0.
    function automatic logic [2:0] next_offset(input logic [2:0] off);
        return off + 3'd1;
    endfunction

endpackage

// File: rtl/serdes_word_aligner_if.sv
// Word-side bus of the SERDES word aligner.
// With SERDES_WORD_ALIGNER_STATS_EN defined the bus also carries SLIP_COUNT.
interface serdes_word_aligner_if;
    import serdes_pkg::*;

    logic [SERDES_DATA_WIDTH-1:0] DATA_IN;
    logic                         RELOCK;
    logic [SERDES_DATA_WIDTH-1:0] DATA_OUT;
    logic                         DATA_VALID;
    logic                         LOCKED;
    logic [2:0]                   OFFSET;
`ifdef SERDES_WORD_ALIGNER_STATS_EN
    logic [7:0]                   SLIP_COUNT;
`endif

    // Source side: the ISERDES wrapper plus whatever consumes the framed words.
    modport master (
        output DATA_IN,
        output RELOCK,
        input  DATA_OUT,
        input  DATA_VALID,
        input  LOCKED,
`ifdef SERDES_WORD_ALIGNER_STATS_EN
        input  SLIP_COUNT,
`endif
        input  OFFSET
    );

    // Aligner side.
    modport slave (
        input  DATA_IN,
        input  RELOCK,
        output DATA_OUT,
        output DATA_VALID,
        output LOCKED,
`ifdef SERDES_WORD_ALIGNER_STATS_EN
        output SLIP_COUNT,
`endif
        output OFFSET
    );

endinterface

// File: rtl/serdes_bit_shifter.sv
// Fabric barrel shifter: keeps the previous ISERDES word and selects the
// WIDTH-bit window starting at bit 'offset' of {data_in, previous word}.
// Bit 0 of every word is the earliest-received bit.
module serdes_bit_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLKDIV,
    input  logic             RST,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       offset,
    output logic [WIDTH-1:0] window
);

    logic [WIDTH-1:0]   prev_q_r;
    logic [2*WIDTH-1:0] stream_s;

    // Hold the previous word so a window can straddle two ISERDES words.
    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            prev_q_r <= {WIDTH{1'b0}};
        end else begin
            prev_q_r <= data_in;
        end
    end

    // Select the window at the current offset from the two-word stream.
    always_comb begin
        stream_s = {data_in, prev_q_r};
        window   = stream_s[offset +: WIDTH];
    end

endmodule

// File: rtl/serdes_word_aligner.sv
// Word aligner behind an 8:1 SDR ISERDES, clocked on CLKDIV.
// Steps a fabric barrel-shift offset until the training word is seen
// MATCH_COUNT times in a row, then locks and frames the payload.
// Optional: SERDES_WORD_ALIGNER_STATS_EN adds SLIP_COUNT (offset steps since
// reset or the last RELOCK, saturating at 8'hFF, frozen while locked).
module serdes_word_aligner
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = SERDES_DATA_WIDTH,
    parameter logic [7:0]  TRAIN_PATTERN = SERDES_TRAIN_PATTERN,
    parameter int unsigned MATCH_COUNT   = 4,
    parameter int unsigned SETTLE        = 1
) (
    input  logic                 CLKDIV,
    input  logic                 RST,
    serdes_word_aligner_if.slave bus
);

    localparam logic [3:0] MATCH_COUNT_C = 4'(MATCH_COUNT);
    localparam logic [2:0] SETTLE_C      = 3'(SETTLE);

    state_e          state_r;
    state_e          state_next_s;
    logic [2:0]      offset_r;
    logic [2:0]      offset_next_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_next_s;
    logic [2:0]      wait_r;
    logic [2:0]      wait_next_s;
    logic            locked_r;
    logic            valid_r;
    logic [7:0]      data_out_r;
    logic [7:0]      window_s;
    logic            match_s;
    logic            relock_s;

    serdes_bit_shifter #(
        .WIDTH (DATA_WIDTH)
    ) u_shifter (
        .CLKDIV  (CLKDIV),
        .RST     (RST),
        .data_in (bus.DATA_IN),
        .offset  (offset_r),
        .window  (window_s)
    );

    // Training-word compare on the currently selected window.
    always_comb begin
        match_s  = (window_s == TRAIN_PATTERN);
        relock_s = bus.RELOCK;
    end

    // Next-state logic: search, settle after each slip, verify, lock.
    always_comb begin
        state_next_s  = state_r;
        offset_next_s = offset_r;
        cnt_next_s    = cnt_r;
        wait_next_s   = wait_r;
        if (relock_s) begin
            // Restart from the current offset; RELOCK beats a same-cycle match.
            state_next_s = ST_SEARCH;
            cnt_next_s   = 4'd0;
            wait_next_s  = 3'd0;
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    if (match_s) begin
                        cnt_next_s   = 4'd1;
                        state_next_s = (MATCH_COUNT_C <= 4'd1) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        offset_next_s = next_offset(offset_r);
                        cnt_next_s    = 4'd0;
                        wait_next_s   = SETTLE_C;
                        state_next_s  = (SETTLE_C == 3'd0) ? ST_SEARCH : ST_SETTLING;
                    end
                end
                ST_SETTLING: begin
                    // The shifted window is not trusted until the gap has elapsed.
                    if (wait_r <= 3'd1) begin
                        wait_next_s  = 3'd0;
                        state_next_s = ST_SEARCH;
                    end else begin
                        wait_next_s  = wait_r - 3'd1;
                        state_next_s = ST_SETTLING;
                    end
                end
                ST_VERIFY: begin
                    if (match_s) begin
                        cnt_next_s = cnt_r + 4'd1;
                        if ((cnt_r + 4'd1) >= MATCH_COUNT_C) begin
                            state_next_s = ST_LOCKED;
                        end else begin
                            state_next_s = ST_VERIFY;
                        end
                    end else begin
                        offset_next_s = next_offset(offset_r);
                        cnt_next_s    = 4'd0;
                        wait_next_s   = SETTLE_C;
                        state_next_s  = (SETTLE_C == 3'd0) ? ST_SEARCH : ST_SETTLING;
                    end
                end
                ST_LOCKED: begin
                    // Payload never matches the training word; ignore it.
                    state_next_s = ST_LOCKED;
                end
                default: begin
                    state_next_s  = ST_SEARCH;
                    cnt_next_s    = 4'd0;
                    wait_next_s   = 3'd0;
                end
            endcase
        end
    end

    // FSM state, counters and offset registers.
    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            state_r  <= ST_SEARCH;
            offset_r <= 3'd0;
            cnt_r    <= 4'd0;
            wait_r   <= 3'd0;
        end else begin
            state_r  <= state_next_s;
            offset_r <= offset_next_s;
            cnt_r    <= cnt_next_s;
            wait_r   <= wait_next_s;
        end
    end

    // Registered outputs; DATA_VALID trails LOCKED by one cycle to track DATA_OUT.
    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            locked_r   <= 1'b0;
            valid_r    <= 1'b0;
            data_out_r <= 8'h00;
        end else begin
            locked_r   <= (state_next_s == ST_LOCKED);
            valid_r    <= locked_r;
            data_out_r <= window_s;
        end
    end

    assign bus.DATA_OUT   = data_out_r;
    assign bus.DATA_VALID = valid_r;
    assign bus.LOCKED     = locked_r;
    assign bus.OFFSET     = offset_r;

`ifdef SERDES_WORD_ALIGNER_STATS_EN
    logic [7:0] slip_r;
    logic       slip_inc_s;

    // An offset step is the only way the offset ever changes.
    always_comb begin
        slip_inc_s = (offset_next_s != offset_r);
    end

    // Saturating slip counter, cleared on RELOCK; cannot move while locked.
    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            slip_r <= 8'h00;
        end else if (relock_s) begin
            slip_r <= 8'h00;
        end else if (slip_inc_s && (slip_r != 8'hFF)) begin
            slip_r <= slip_r + 8'd1;
        end else begin
            slip_r <= slip_r;
        end
    end

    assign bus.SLIP_COUNT = slip_r;
`endif

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Self-checking bench for serdes_word_aligner (default parameters).
// Directed vector table plus hand sequences, and a behavioural model that
// follows the alignment rules on a bit stream, compared every cycle.
// SLIP_COUNT is checked when SERDES_WORD_ALIGNER_STATS_EN is defined.
module tb_serdes_word_aligner;

    localparam logic [7:0] PAT = 8'hB4;
    localparam int         MC  = 4;
    localparam int         STL = 1;

    logic CLKDIV = 1'b0;
    logic RST    = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serdes_word_aligner_if bus();

    serdes_word_aligner #(
        .DATA_WIDTH    (8),
        .TRAIN_PATTERN (PAT),
        .MATCH_COUNT   (MC),
        .SETTLE        (STL)
    ) dut (
        .CLKDIV (CLKDIV),
        .RST    (RST),
        .bus    (bus)
    );

    always #5 CLKDIV = ~CLKDIV;

    // Reference model state: offset, previous word, pending idle cycles,
    // consecutive hits, lock flag, outputs.
    int m_prev, m_off, m_idle, m_hits, m_slip, m_dout;
    bit m_lock, m_valid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [15:0] t;
        t = {8'h00, v} << k;
        return t[7:0] | t[15:8];
    endfunction

    // One clock of the alignment rules, in terms of the received bit stream.
    task automatic model_step(input bit rst, input bit rl, input int din);
        int w;
        w = ((din * 256 + m_prev) >> m_off) & 255;
        if (rst) begin
            m_prev = 0; m_off = 0; m_idle = 0; m_hits = 0; m_slip = 0;
            m_dout = 0; m_lock = 0; m_valid = 0;
        end else begin
            m_valid = m_lock;
            m_dout  = w;
            m_prev  = din;
            if (rl) begin
                m_lock = 0; m_hits = 0; m_idle = 0; m_slip = 0;
            end else if (m_lock) begin
                m_lock = 1;
            end else if (m_idle > 0) begin
                m_idle--;
            end else if (w == PAT) begin
                m_hits++;
                if (m_hits >= MC) m_lock = 1;
            end else begin
                m_off  = (m_off + 1) % 8;
                m_hits = 0;
                m_idle = STL;
                if (m_slip < 255) m_slip++;
            end
        end
    endtask

    task automatic cmp_model();
        chk("model.DATA_OUT",   32'(bus.DATA_OUT),   32'(m_dout));
        chk("model.DATA_VALID", 32'(bus.DATA_VALID), 32'(m_valid));
        chk("model.LOCKED",     32'(bus.LOCKED),     32'(m_lock));
        chk("model.OFFSET",     32'(bus.OFFSET),     32'(m_off));
`ifdef SERDES_WORD_ALIGNER_STATS_EN
        chk("model.SLIP_COUNT", 32'(bus.SLIP_COUNT), 32'(m_slip));
`endif
    endtask

    // Drive inputs, step the model, clock, sample on the falling edge.
    task automatic cycle(input bit rst, input bit rl, input logic [7:0] din, input bit use_model);
        RST         = rst;
        bus.RELOCK  = rl;
        bus.DATA_IN = din;
        model_step(rst, rl, int'(din));
        @(posedge CLKDIV);
        @(negedge CLKDIV);
        if (use_model) cmp_model();
    endtask

    typedef struct {
        logic       rst;
        logic       rl;
        logic [7:0] din;
        logic       locked;
        logic       valid;
        logic [2:0] off;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [7:0] w5, w2, pay, d;
        logic [7:0] hist[$];
        int         offs[$];
        int         exp_offs[6];
        int         n, k, len;

        bus.RELOCK  = 1'b0;
        bus.DATA_IN = 8'h00;

        // Offset 3: A5 repeated puts the B4 word boundary at stream bit 3.
        tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hD2};
        tbl[5]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd2, 8'hD2};
        tbl[6]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd2, 8'h69};
        tbl[7]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'h69};
        tbl[8]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'hB4};
        tbl[9]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'hB4};
        tbl[10] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'hB4};
        tbl[11] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'hB4};
        tbl[12] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd3, 8'hB4};
        tbl[13] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 3'd3, 8'hB4};
        tbl[14] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd3, 8'hB4};
        tbl[15] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'hB4};
        tbl[16] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'hB4};
        tbl[17] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd3, 8'hB4};
        tbl[18] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd3, 8'hB4};

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].rst, tbl[i].rl, tbl[i].din, 1'b0);
            chk($sformatf("tbl%0d.LOCKED", i),     32'(bus.LOCKED),     32'(tbl[i].locked));
            chk($sformatf("tbl%0d.DATA_VALID", i), 32'(bus.DATA_VALID), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d.OFFSET", i),     32'(bus.OFFSET),     32'(tbl[i].off));
            chk($sformatf("tbl%0d.DATA_OUT", i),   32'(bus.DATA_OUT),   32'(tbl[i].dout));
`ifdef SERDES_WORD_ALIGNER_STATS_EN
            if (i == 12) chk("tbl12.SLIP_COUNT", 32'(bus.SLIP_COUNT), 32'd3);
            if (i == 14) chk("tbl14.SLIP_COUNT", 32'(bus.SLIP_COUNT), 32'd0);
`endif
        end

        // Constant B4 from reset: the zeroed previous word costs one full
        // sweep of the offsets, so lock lands on the 20th edge at offset 0.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, PAT, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b0, PAT, 1'b1);
            if (i == 19) chk("zero.not_yet_locked", 32'(bus.LOCKED), 32'd0);
        end
        chk("zero.LOCKED",   32'(bus.LOCKED),   32'd1);
        chk("zero.OFFSET",   32'(bus.OFFSET),   32'd0);
        chk("zero.DATA_OUT", 32'(bus.DATA_OUT), 32'(PAT));
        chk("zero.VALID_lags", 32'(bus.DATA_VALID), 32'd0);

        // Locked robustness: payload flows through with 2-cycle latency.
        hist.push_back(PAT);
        for (int i = 0; i < 30; i++) begin
            pay = 8'($urandom);
            hist.push_back(pay);
            cycle(1'b0, 1'b0, pay, 1'b1);
            chk("lock.LOCKED",   32'(bus.LOCKED),   32'd1);
            chk("lock.DATA_OUT", 32'(bus.DATA_OUT), 32'(hist[hist.size()-2]));
        end
        chk("lock.DATA_VALID", 32'(bus.DATA_VALID), 32'd1);

        // RELOCK drops LOCKED on the next edge; then verify failure at offset 0.
        cycle(1'b0, 1'b1, PAT, 1'b1);
        chk("relock.LOCKED", 32'(bus.LOCKED), 32'd0);
        cycle(1'b0, 1'b0, PAT, 1'b1);
        chk("vfail.LOCKED1", 32'(bus.LOCKED), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("vfail.LOCKED2", 32'(bus.LOCKED), 32'd0);
        cycle(1'b0, 1'b0, PAT, 1'b1);
        chk("vfail.LOCKED3", 32'(bus.LOCKED), 32'd0);
        chk("vfail.OFFSET",  32'(bus.OFFSET), 32'd1);

        // Wrap: lock at 5, RELOCK, re-phase to 2 -> offsets 5,6,7,0,1,2.
        w5 = rotl(PAT, 5);
        w2 = rotl(PAT, 2);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, w5, 1'b1);
        n = 0;
        while (bus.LOCKED !== 1'b1 && n < 40) begin
            cycle(1'b0, 1'b0, w5, 1'b1);
            n++;
        end
        chk("wrap.lock5", 32'(bus.LOCKED), 32'd1);
        chk("wrap.off5",  32'(bus.OFFSET), 32'd5);
        cycle(1'b0, 1'b1, w2, 1'b1);
        offs.push_back(int'(bus.OFFSET));
        n = 0;
        while (bus.LOCKED !== 1'b1 && n < 40) begin
            cycle(1'b0, 1'b0, w2, 1'b1);
            if (int'(bus.OFFSET) != offs[offs.size()-1]) offs.push_back(int'(bus.OFFSET));
            n++;
        end
        exp_offs = '{5, 6, 7, 0, 1, 2};
        chk("wrap.seq_len", 32'(offs.size()), 32'd6);
        for (int i = 0; i < 6 && i < offs.size(); i++)
            chk($sformatf("wrap.seq%0d", i), 32'(offs[i]), 32'(exp_offs[i]));
        chk("wrap.lock2", 32'(bus.LOCKED), 32'd1);

        // RST mid-VERIFY (and over a same-cycle RELOCK) zeroes all outputs.
        cycle(1'b0, 1'b1, w2, 1'b1);
        cycle(1'b0, 1'b0, w2, 1'b1);
        cycle(1'b1, 1'b1, w2, 1'b1);
        chk("rst.DATA_OUT",   32'(bus.DATA_OUT),   32'd0);
        chk("rst.DATA_VALID", 32'(bus.DATA_VALID), 32'd0);
        chk("rst.LOCKED",     32'(bus.LOCKED),     32'd0);
        chk("rst.OFFSET",     32'(bus.OFFSET),     32'd0);

        // Randomized segments of rotated training words with noise, RELOCK, RST.
        for (int s = 0; s < 25; s++) begin
            k   = $urandom_range(0, 7);
            len = $urandom_range(8, 40);
            for (int i = 0; i < len; i++) begin
                d = rotl(PAT, k);
                if ($urandom_range(0, 15) == 0) d = 8'($urandom);
                cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0), d, 1'b1);
            end
        end

        // No pattern at all: offsets cycle forever, slip count saturates.
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 2100; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("nopat.LOCKED", 32'(bus.LOCKED), 32'd0);
`ifdef SERDES_WORD_ALIGNER_STATS_EN
        chk("nopat.SLIP_COUNT", 32'(bus.SLIP_COUNT), 32'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
